// File: rtl/hamming_decode_scheduler_if.sv
// Handshake bundle between the two link receive buffers, the scheduler and the data sink.
interface hamming_decode_scheduler_if;
    logic       req0_valid;
    logic [6:0] req0_code;
    logic       req0_odd;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_code;
    logic       req1_odd;
    logic       req1_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_src;
    logic       out_err;

    // Requester/sink side
    modport master (
        output req0_valid, req0_code, req0_odd,
        input  req0_ready,
        output req1_valid, req1_code, req1_odd,
        input  req1_ready,
        input  out_valid, out_data, out_src, out_err,
        output out_ready
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_code, req0_odd,
        output req0_ready,
        input  req1_valid, req1_code, req1_odd,
        output req1_ready,
        output out_valid, out_data, out_src, out_err,
        input  out_ready
    );
endinterface

// File: rtl/hamming_decode_scheduler.sv
// Round-robin scheduler sharing one combinational Hamming(7,4) decoder between two
// requesters; registers the decoded nibble and keeps saturating word/error counters.
module hamming_decode_scheduler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hamming_decode_scheduler_if.slave     bus,
    output logic                          dec_select,
    output logic [6:0]                    dec_x,
    input  logic [3:0]                    dec_y,
    input  logic                          clr_cnt,
    output logic [CNT_W-1:0]              word_cnt,
    output logic [CNT_W-1:0]              err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [6:0]       dec_x_q, dec_x_d;
    logic             dec_select_q, dec_select_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       grant;
    logic       any_valid;
    logic       out_hs;
    logic [2:0] syn;
    logic       syn_data;

    // Arbitration, syndrome evaluation, next-state and counter update
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dec_x_d      = dec_x_q;
        dec_select_d = dec_select_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_err_d    = out_err_q;
        word_cnt_d   = word_cnt_q;
        err_cnt_d    = err_cnt_q;
        out_hs       = 1'b0;

        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

        // rst_n gating keeps both readies low while reset is held
        bus.req0_ready = rst_n & (state_q == IDLE) & ~grant & bus.req0_valid;
        bus.req1_ready = rst_n & (state_q == IDLE) &  grant & bus.req1_valid;

        syn[0]   = dec_x_q[0] ^ dec_x_q[2] ^ dec_x_q[4] ^ dec_x_q[6];
        syn[1]   = dec_x_q[1] ^ dec_x_q[2] ^ dec_x_q[5] ^ dec_x_q[6];
        syn[2]   = dec_x_q[3] ^ dec_x_q[4] ^ dec_x_q[5] ^ dec_x_q[6];
        syn      = syn ^ {3{dec_select_q}};
        // Two or more syndrome bits set points at a data bit (positions 3,5,6,7)
        syn_data = (syn[0] & syn[1]) | (syn[0] & syn[2]) | (syn[1] & syn[2]);

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    // The captured code lives directly in the decoder drive register;
                    // last_grant doubles as the source of the word in flight
                    dec_x_d      = grant ? bus.req1_code : bus.req0_code;
                    dec_select_d = grant ? bus.req1_odd  : bus.req0_odd;
                    last_grant_d = grant;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                out_data_d  = syn_data ? dec_y : {dec_x_q[6], dec_x_q[5], dec_x_q[4], dec_x_q[2]};
                out_err_d   = (syn != 3'd0);
                out_src_d   = last_grant_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_hs      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_cnt) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (out_hs) begin
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
            if (out_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            dec_x_q      <= '0;
            dec_select_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            out_err_q    <= 1'b0;
            word_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dec_x_q      <= dec_x_d;
            dec_select_q <= dec_select_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_err_q    <= out_err_d;
            word_cnt_q   <= word_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dec_x         = dec_x_q;
    assign dec_select    = dec_select_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_err   = out_err_q;
    assign word_cnt      = word_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Directed bench for hamming_decode_scheduler: main instance (CNT_W=16) plus a
// CNT_W=2 instance for counter saturation.
module tb_hamming_decode_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_decode_scheduler_if bus ();
    hamming_decode_scheduler_if bus_b ();

    logic        dec_select, dec_select_b;
    logic [6:0]  dec_x, dec_x_b;
    logic [3:0]  dec_y, dec_y_b;
    logic        clr_cnt, clr_cnt_b;
    logic [15:0] word_cnt, err_cnt;
    logic [1:0]  word_cnt_b, err_cnt_b;

    int checks = 0;
    int failures = 0;

    // Reference single-error-correcting decoder standing in for the shared decoder
    function automatic logic [3:0] dec_model(input logic [6:0] x, input logic odd);
        logic [6:0] c;
        logic [2:0] s;
        c = x;
        s[0] = x[0] ^ x[2] ^ x[4] ^ x[6];
        s[1] = x[1] ^ x[2] ^ x[5] ^ x[6];
        s[2] = x[3] ^ x[4] ^ x[5] ^ x[6];
        s = s ^ {3{odd}};
        if (s != 3'd0) c[int'(s) - 1] = ~c[int'(s) - 1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    assign dec_y   = dec_model(dec_x, dec_select);
    assign dec_y_b = dec_model(dec_x_b, dec_select_b);

    hamming_decode_scheduler #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dec_select (dec_select),
        .dec_x      (dec_x),
        .dec_y      (dec_y),
        .clr_cnt    (clr_cnt),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt)
    );

    hamming_decode_scheduler #(.CNT_W(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_b),
        .dec_select (dec_select_b),
        .dec_x      (dec_x_b),
        .dec_y      (dec_y_b),
        .clr_cnt    (clr_cnt_b),
        .word_cnt   (word_cnt_b),
        .err_cnt    (err_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        bus.req0_valid = 0; bus.req0_code = '0; bus.req0_odd = 0;
        bus.req1_valid = 0; bus.req1_code = '0; bus.req1_odd = 0;
        bus.out_ready = 0; clr_cnt = 0;
        bus_b.req0_valid = 0; bus_b.req0_code = '0; bus_b.req0_odd = 0;
        bus_b.req1_valid = 0; bus_b.req1_code = '0; bus_b.req1_odd = 0;
        bus_b.out_ready = 0; clr_cnt_b = 0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_dec_x", 32'(dec_x), 0);
        rst_n = 1'b1;
        tick();

        // Clean even word on ch0, latency 2
        bus.req0_valid = 1; bus.req0_code = 7'b1010101; bus.req0_odd = 0;
        #1;
        chk("clean_req0_ready", 32'(bus.req0_ready), 1);
        chk("clean_req1_ready", 32'(bus.req1_ready), 0);
        tick();
        bus.req0_valid = 0;
        chk("clean_lat_n1_valid", 32'(bus.out_valid), 0);
        chk("clean_dec_x", 32'(dec_x), 32'h55);
        chk("clean_dec_select", 32'(dec_select), 0);
        tick();
        chk("clean_valid", 32'(bus.out_valid), 1);
        chk("clean_data", 32'(bus.out_data), 4'b1011);
        chk("clean_err", 32'(bus.out_err), 0);
        chk("clean_src", 32'(bus.out_src), 0);

        // Backpressure for 10 cycles while ch1 waits
        bus.req1_valid = 1; bus.req1_code = 7'b1010001; bus.req1_odd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 4'b1011);
            chk("bp_req0_ready", 32'(bus.req0_ready), 0);
            chk("bp_req1_ready", 32'(bus.req1_ready), 0);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("hs1_valid", 32'(bus.out_valid), 0);
        chk("hs1_word_cnt", 32'(word_cnt), 1);
        chk("hs1_err_cnt", 32'(err_cnt), 0);
        chk("ch1_ready", 32'(bus.req1_ready), 1);

        // Data-bit error on ch1 (x2 flipped, s=3)
        tick();
        bus.req1_valid = 0;
        tick();
        chk("dbe_data", 32'(bus.out_data), 4'b1011);
        chk("dbe_err", 32'(bus.out_err), 1);
        chk("dbe_src", 32'(bus.out_src), 1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("dbe_err_cnt", 32'(err_cnt), 1);
        chk("dbe_word_cnt", 32'(word_cnt), 2);

        // Parity-bit error on ch0 (x0 flipped, s=1): raw data bits
        bus.req0_valid = 1; bus.req0_code = 7'b1010100; bus.req0_odd = 0;
        tick();
        bus.req0_valid = 0;
        tick();
        chk("pbe_data", 32'(bus.out_data), 4'b1011);
        chk("pbe_err", 32'(bus.out_err), 1);
        chk("pbe_src", 32'(bus.out_src), 0);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;

        // Odd parity on ch1: even-clean word reads as s=7, x6 corrected
        bus.req1_valid = 1; bus.req1_code = 7'b1010101; bus.req1_odd = 1;
        tick();
        bus.req1_valid = 0;
        chk("odd_dec_select", 32'(dec_select), 1);
        tick();
        chk("odd_data", 32'(bus.out_data), 4'b0011);
        chk("odd_err", 32'(bus.out_err), 1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("odd_word_cnt", 32'(word_cnt), 4);
        chk("odd_err_cnt", 32'(err_cnt), 3);

        // Clear, then both channels valid continuously
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        chk("clr_word_cnt", 32'(word_cnt), 0);
        chk("clr_err_cnt", 32'(err_cnt), 0);
        bus.req0_valid = 1; bus.req0_code = 7'b1010101; bus.req0_odd = 0;
        bus.req1_valid = 1; bus.req1_code = 7'b0000000; bus.req1_odd = 0;
        bus.out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            budget = 0;
            while (!bus.out_valid && budget < 10) begin
                tick();
                budget++;
            end
            chk("arb_valid", 32'(bus.out_valid), 1);
            chk("arb_src", 32'(bus.out_src), 32'(k % 2));
            chk("arb_data", 32'(bus.out_data), (k % 2 == 0) ? 32'hB : 32'h0);
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.out_ready = 0;
        chk("arb_word_cnt", 32'(word_cnt), 4);
        chk("arb_err_cnt", 32'(err_cnt), 0);

        // clr_cnt coincident with a handshake
        tick();
        bus.req0_valid = 1; bus.req0_code = 7'b1010001; bus.req0_odd = 0;
        tick();
        bus.req0_valid = 0;
        tick();
        chk("clrhs_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1; clr_cnt = 1;
        tick();
        bus.out_ready = 0; clr_cnt = 0;
        chk("clrhs_word_cnt", 32'(word_cnt), 0);
        chk("clrhs_err_cnt", 32'(err_cnt), 0);

        // One delivery, then reset asserted asynchronously while in HOLD
        bus.req0_valid = 1; bus.req0_code = 7'b1010101; bus.req0_odd = 0;
        bus.out_ready = 1;
        tick(); tick(); tick();
        bus.out_ready = 0;
        chk("pre_rst_word_cnt", 32'(word_cnt), 1);
        tick(); tick();
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_req0_ready", 32'(bus.req0_ready), 0);
        chk("arst_word_cnt", 32'(word_cnt), 0);
        chk("arst_dec_x", 32'(dec_x), 0);
        bus.req0_valid = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Saturation on the CNT_W=2 instance: erroneous words delivered back to back
        bus_b.req0_valid = 1; bus_b.req0_code = 7'b1010001; bus_b.req0_odd = 0;
        bus_b.out_ready = 1;
        repeat (18) tick();
        bus_b.req0_valid = 0;
        chk("sat_word_cnt", 32'(word_cnt_b), 3);
        chk("sat_err_cnt", 32'(err_cnt_b), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
